// File: rtl/app_mul_seq_radix4_unsigned.sv
// Sequential radix-4 unsigned multiplier: consumes two multiplier bits per cycle and accumulates layer sums.
// Optional macro APPROX_TRUNC_EN clears layer bits below absolute column TRUNC_BITS before accumulation.
module app_mul_seq_radix4_unsigned #(
    parameter int WIDTH_A    = 8,
    parameter int WIDTH_B    = 8,
    parameter int TRUNC_BITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_p,
    output logic                       busy
);

    localparam int N  = WIDTH_B / 2;
    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH_A < 2 || WIDTH_B < 2 || (WIDTH_B % 2) != 0 ||
        TRUNC_BITS < 0 || TRUNC_BITS >= WIDTH_A) begin : g_bad_params
        $error("app_mul_seq_radix4_unsigned: illegal parameter combination");
    end

`ifdef APPROX_TRUNC_EN
    localparam logic [PW-1:0] TRUNC_MASK = ~((PW'(1) << TRUNC_BITS) - PW'(1));
`endif

    // LOAD is the single cycle that copies the finished accumulator into the output register.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOAD,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_A-1:0]   a_q, a_d;
    logic [WIDTH_B-1:0]   b_q, b_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [KW-1:0]        k_q, k_d;
    logic [PW-1:0]        p_q, p_d;

    logic [1:0]           digit;
    logic [WIDTH_A+1:0]   layer;
    logic [PW-1:0]        term;

    // The multiplier register shifts right by one digit per layer, so the live digit is always b_q[1:0].
    always_comb begin
        digit = b_q[1:0];
        unique case (digit)
            2'd0:    layer = '0;
            2'd1:    layer = {2'b00, a_q};
            2'd2:    layer = {1'b0, a_q, 1'b0};
            default: layer = {2'b00, a_q} + {1'b0, a_q, 1'b0};
        endcase
        term = PW'(layer) << {k_q, 1'b0};
`ifdef APPROX_TRUNC_EN
        term = term & TRUNC_MASK;
`endif
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        k_d       = k_q;
        p_d       = p_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                acc_d = acc_q + term;
                b_d   = b_q >> 2;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                p_d     = acc_q;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_p = p_q;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_app_mul_seq_radix4_unsigned.sv
// Scoreboard bench for app_mul_seq_radix4_unsigned: expected products queued at acceptance, compared at handshake.
module tb_app_mul_seq_radix4_unsigned;

    localparam int WA    = 8;
    localparam int WB    = 8;
    localparam int TRUNC = 2;
    localparam int NL    = WB / 2;
    localparam int PW    = WA + WB;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [WA-1:0] in_a      = '0;
    logic [WB-1:0] in_b      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [PW-1:0] out_p;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_products = 0;
    int n_accepted = 0;
    logic [PW-1:0] sb[$];

    app_mul_seq_radix4_unsigned #(
        .WIDTH_A   (WA),
        .WIDTH_B   (WB),
        .TRUNC_BITS(TRUNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact radix-4 layer sum, optionally with low columns truncated per layer.
    function automatic logic [PW-1:0] model(input logic [WA-1:0] a, input logic [WB-1:0] b);
        logic [PW-1:0] sum;
        logic [PW-1:0] t;
        logic [1:0]    d;
        sum = '0;
        for (int k = 0; k < NL; k++) begin
            d = b[2*k +: 2];
            t = (PW'(a) * PW'(d)) << (2 * k);
`ifdef APPROX_TRUNC_EN
            t = t & ~((PW'(1) << TRUNC) - PW'(1));
`endif
            sum = sum + t;
        end
        return sum;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an operand pair, check latency cycle by cycle; optionally poke in_valid during RUN.
    task automatic do_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input bit poke);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sb.push_back(model(a, b));
        n_accepted++;
        check("busy_after_accept", busy, 1);
        check("in_ready_low_in_run", in_ready, 0);
        for (int i = 1; i <= NL + 1; i++) begin
            if (poke && i == 2) begin
                in_a = 8'd7;
                in_b = 8'd7;
                in_valid = 1'b1;
            end
            step();
            in_valid = 1'b0;
            check($sformatf("out_valid_lat%0d", i), out_valid, (i == NL + 1));
        end
    endtask

    task automatic finish_op();
        step();
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_products++;
            if (sb.size() == 0) begin
                check("spurious_product", 32'(sb.size()), 1);
            end else begin
                check("out_p", out_p, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] m;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();

        do_op(8'd13, 8'd11, 1'b0);
        check("p_13x11", out_p, model(8'd13, 8'd11));
        finish_op();

        do_op(8'd255, 8'd255, 1'b0);
        finish_op();
        check("p_255x255_retained", out_p, model(8'd255, 8'd255));

        out_ready = 1'b0;
        do_op(8'd200, 8'd3, 1'b0);
        m = model(8'd200, 8'd3);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_p", out_p, m);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_single_handshake", out_valid, 0);
        end
        out_ready = 1'b1;

        do_op(8'd9, 8'd9, 1'b1);
        finish_op();
        for (int i = 0; i < NL + 4; i++) begin
            step();
            check("no_second_product", out_valid, 0);
        end
        check("ignored_count", n_products, n_accepted);

        do_op(8'd0, 8'd170, 1'b0);
        finish_op();
        do_op(8'd255, 8'd0, 1'b0);
        finish_op();

        for (int i = 0; i < 4; i++) begin
            do_op(WA'($urandom_range(0, 255)), WB'($urandom_range(0, 255)), 1'b0);
            finish_op();
        end

        // Reset during the second RUN cycle of 100x100; the in-flight product is discarded.
        in_a = 8'd100;
        in_b = 8'd100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sb.push_back(model(8'd100, 8'd100));
        step();
        check("pre_reset_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_p", out_p, 0);
        void'(sb.pop_back());
        step();
        rst = 1'b0;
        step();
        do_op(8'd6, 8'd7, 1'b0);
        check("p_6x7", out_p, 42);
        finish_op();

        step();
        check("sb_drained", 32'(sb.size()), 0);
        check("product_count", n_products, n_accepted);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
